// File: rtl/lfsr_pkg.sv
// Shared defaults for the keystream LFSR.
//   LFSR_WIDTH     : register and key width
//   LFSR_TAPS      : feedback tap mask; bit i set means state[i] feeds the XOR
//                    (x^8+x^6+x^5+x^4+1, maximal length, period 255)
//   LFSR_ZERO_SEED : seed used when the supplied key is all-zero
package lfsr_pkg;

    localparam int         LFSR_WIDTH     = 8;
    localparam logic [7:0] LFSR_TAPS      = 8'hB8;
    localparam logic [7:0] LFSR_ZERO_SEED = 8'h01;

endpackage : lfsr_pkg

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register with a synchronous parallel load.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset, clears the register to zero
//   load  : when high, the next edge loads seed instead of shifting
//   seed  : value loaded on a load edge
//   state : register contents, straight from the flops
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic             fb;

    // Feedback is the parity of the tapped bits; it enters at the LSB.
    always_comb begin
        fb      = ^(state_q & TAPS);
        state_d = {state_q[WIDTH-2:0], fb};
        if (load) begin
            state_d = seed;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule : lfsr_core

// File: rtl/top.sv
// Keystream generator: loads a key on the first edge after reset release,
// then shifts on every following edge.
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset (release synchronized externally)
//   key      : secret seed, sampled only on the load edge
//   lfsr_bit : keystream bit, equal to state[WIDTH-1]
//   state    : current LFSR contents
module top
    import lfsr_pkg::*;
#(
    parameter int               WIDTH     = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(LFSR_TAPS),
    parameter logic [WIDTH-1:0] ZERO_SEED = WIDTH'(LFSR_ZERO_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] key,
    output logic             lfsr_bit,
    output logic [WIDTH-1:0] state
);

    logic             load_pending_q;
    logic             load_pending_d;
    logic [WIDTH-1:0] seed;

    // Only the very first edge after reset is a load edge, so the flag
    // simply drops on any clock edge and is re-armed by reset alone.
    always_comb begin
        load_pending_d = 1'b0;
        // An all-zero seed would lock the LFSR at zero forever.
        seed = (key == '0) ? ZERO_SEED : key;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_pending_q <= 1'b1;
        end else begin
            load_pending_q <= load_pending_d;
        end
    end

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .load  (load_pending_q),
        .seed  (seed),
        .state (state)
    );

    assign lfsr_bit = state[WIDTH-1];

endmodule : top

// File: tb/tb_top.sv
// Directed self-checking bench for the keystream LFSR top.
module tb_top;

    logic       clk;
    logic       rst;
    logic [7:0] key;
    logic       lfsr_bit;
    logic [7:0] state;

    int nChecks = 0;
    int nFail   = 0;

    top dut (
        .clk      (clk),
        .rst      (rst),
        .key      (key),
        .lfsr_bit (lfsr_bit),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference step of x^8+x^6+x^5+x^4+1 (taps at bits 7,5,4,3).
    function automatic logic [7:0] modelNext(input logic [7:0] s);
        logic fbBit;
        fbBit = s[7] ^ s[5] ^ s[4] ^ s[3];
        return {s[6:0], fbBit};
    endfunction

    // Advance one rising edge and settle just after it.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Set key, pulse reset low for one clock period, release on a falling edge.
    task automatic applyStimulus(input logic [7:0] newKey);
        @(negedge clk);
        key = newKey;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] expState, input logic expBit);
        nChecks++;
        assert (state === expState) else begin
            nFail++;
            $error("[TB] FAIL %s state observed=%h expected=%h", tag, state, expState);
        end
        nChecks++;
        assert (lfsr_bit === expBit) else begin
            nFail++;
            $error("[TB] FAIL %s lfsr_bit observed=%b expected=%b", tag, lfsr_bit, expBit);
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [7:0] plain;
        logic [7:0] cipher;
        logic [7:0] decrypted;
        logic [7:0] modelState;
        int         zeroSeen;
        int         modelErrs;
        int         firstReturn;

        rst = 1'b1;
        key = 8'hC3;
        #1;
        rst = 1'b0;
        #1;
        checkOutput("async_reset", 8'h00, 1'b0);

        // Basic sequence from key C3, reset held over two edges first.
        stepClock();
        stepClock();
        checkOutput("held_reset", 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        stepClock();
        checkOutput("c3_load", 8'hC3, 1'b1);
        stepClock();
        checkOutput("c3_shift1", 8'h87, 1'b1);
        stepClock();
        checkOutput("c3_shift2", 8'h0F, 1'b0);
        stepClock();
        checkOutput("c3_shift3", 8'h1F, 1'b0);

        // Zero key substitutes the 01 seed.
        applyStimulus(8'h00);
        stepClock();
        checkOutput("zero_key_load", 8'h01, 1'b0);
        stepClock();
        checkOutput("zero_key_shift", 8'h02, 1'b0);

        // Encrypt AB LSB-first with keystream 1,1,0,0,0,0,1,1 -> 68, then decrypt.
        plain = 8'hAB;
        applyStimulus(8'hC3);
        for (int i = 0; i < 8; i++) begin
            stepClock();
            cipher[i] = plain[i] ^ lfsr_bit;
        end
        checkValue("cipher", 32'(cipher), 32'h68);
        applyStimulus(8'hC3);
        for (int i = 0; i < 8; i++) begin
            stepClock();
            decrypted[i] = cipher[i] ^ lfsr_bit;
        end
        checkValue("decrypt", 32'(decrypted), 32'hAB);

        // Reset mid-sequence after five shifts (C3,87,0F,1F,3E,7D).
        applyStimulus(8'hC3);
        stepClock();
        for (int i = 0; i < 5; i++) begin
            stepClock();
        end
        checkOutput("five_shifts", 8'h7D, 1'b0);
        #4;
        rst = 1'b0;
        #1;
        checkOutput("mid_reset", 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        stepClock();
        checkOutput("reload_after_reset", 8'hC3, 1'b1);

        // Key change after the load edge is ignored.
        applyStimulus(8'hC3);
        stepClock();
        checkOutput("keychg_load", 8'hC3, 1'b1);
        @(negedge clk);
        key = 8'h5A;
        stepClock();
        checkOutput("keychg_shift1", 8'h87, 1'b1);
        stepClock();
        checkOutput("keychg_shift2", 8'h0F, 1'b0);
        stepClock();
        checkOutput("keychg_shift3", 8'h1F, 1'b0);

        // Free run 255 shifts from 01: full period, never zero.
        applyStimulus(8'h01);
        stepClock();
        checkOutput("run_load", 8'h01, 1'b0);
        modelState  = 8'h01;
        zeroSeen    = 0;
        modelErrs   = 0;
        firstReturn = 0;
        for (int i = 1; i <= 255; i++) begin
            stepClock();
            modelState = modelNext(modelState);
            if (state === 8'h00) zeroSeen++;
            if (state !== modelState) modelErrs++;
            if (state === 8'h01 && firstReturn == 0) firstReturn = i;
        end
        checkValue("run_final", 32'(state), 32'h01);
        checkValue("run_zero_states", 32'(zeroSeen), 32'd0);
        checkValue("run_model_errors", 32'(modelErrs), 32'd0);
        checkValue("run_period", 32'(firstReturn), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule : tb_top
